config_master_sequencer: RTL and testbench

Master-side sequencer for the UART auto-configuration protocol. When the CPU or the main controller starts a setup, the block sends the configuration packets through the TX FIFO in a fixed order. The packets are: request, data width, parity mode, stop bits, end. After each packet it waits for an acknowledge from the RX FIFO, with a timeout and a bounded number of retries. It then writes the agreed configuration (or the standard configuration on failure) into the configuration register.

---
 rtl/UART_pkg.sv | 85 ++++++++
 rtl/cfg_timeout_counter.sv | 36 +++
 rtl/config_master_sequencer.sv | 160 ++++++++++++++++
 tb/tb_config_master_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/UART_pkg.sv
// Shared UART configuration types plus the auto-configuration protocol
// constants used by the master-side sequencer.
package UART_pkg;

    typedef struct packed {
        logic [1:0] data_width;
        logic [1:0] parity_mode;
        logic [1:0] stop_bits;
    } uart_config_s;

    // Standard configuration: 8 data bits, no parity, 1 stop bit
    localparam logic [1:0] STD_DATA_WIDTH  = 2'b11;
    localparam logic [1:0] STD_PARITY_MODE = 2'b00;
    localparam logic [1:0] STD_STOP_BITS   = 2'b00;
    localparam uart_config_s STD_CONFIG = '{
        data_width:  STD_DATA_WIDTH,
        parity_mode: STD_PARITY_MODE,
        stop_bits:   STD_STOP_BITS
    };

    localparam logic [1:0] RESERVED = 2'b11;

    localparam logic [5:0] CFG_REQ_ID        = 6'h30;
    localparam logic [5:0] DATA_WIDTH_ID     = 6'h31;
    localparam logic [5:0] PARITY_MODE_ID    = 6'h32;
    localparam logic [5:0] STOP_BITS_ID      = 6'h33;
    localparam logic [5:0] END_CONFIGURATION = 6'h34;
    localparam logic [7:0] ACKN_PKT          = 8'hFC;

    localparam logic [2:0] LAST_PKT_IDX = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        APPLY,
        FALLBACK
    } cfg_seq_fsm_e;

    typedef enum logic [1:0] {
        CS_OK        = 2'd0,
        CS_SANITIZED = 2'd1,
        CS_TIMEOUT   = 2'd2,
        CS_BAD_ACK   = 2'd3
    } cfg_seq_status_e;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] option;
    } cfg_packet_fields_s;

    typedef union packed {
        logic [7:0]         raw;
        cfg_packet_fields_s f;
    } cfg_packet_u;

    function automatic logic [7:0] cfg_packet(input logic [2:0] idx, input uart_config_s cfg);
        cfg_packet_u pkt;
        pkt.raw = 8'h00;
        case (idx)
            3'd0: begin
                pkt.f.id     = CFG_REQ_ID;
                pkt.f.option = 2'b00;
            end
            3'd1: begin
                pkt.f.id     = DATA_WIDTH_ID;
                pkt.f.option = cfg.data_width;
            end
            3'd2: begin
                pkt.f.id     = PARITY_MODE_ID;
                pkt.f.option = cfg.parity_mode;
            end
            3'd3: begin
                pkt.f.id     = STOP_BITS_ID;
                pkt.f.option = cfg.stop_bits;
            end
            default: begin
                pkt.f.id     = END_CONFIGURATION;
                pkt.f.option = 2'b00;
            end
        endcase
        return pkt.raw;
    endfunction

endpackage

// File: rtl/cfg_timeout_counter.sv
// Acknowledge-wait counter: terminal pulse on the enabled cycle in which the
// incremented count reaches TIMEOUT_CYCLES-1.
module cfg_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The owner leaves the wait state on this pulse, so the count never wraps
    assign tc_o = enable_i && (cnt_q == CW'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/config_master_sequencer.sv
// Master-side UART auto-configuration sequencer: sends the five config
// packets, waits for each acknowledge with timeout/retry, then applies a config.
module config_master_sequencer
    import UART_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  uart_config_s cfg_i,
    input  logic         tx_fifo_full_i,
    output logic         tx_fifo_write_o,
    output logic [7:0]   tx_data_o,
    input  logic         rx_fifo_empty_i,
    input  logic [7:0]   rx_data_i,
    output logic         rx_fifo_read_o,
    output logic         busy_o,
    output logic         CFR_en_o,
    output uart_config_s config_o,
    output logic         done_o,
    output logic [1:0]   status_o
);
    localparam int RW = $clog2(MAX_RETRY + 1);

    cfg_seq_fsm_e    state_q, state_d;
    logic [2:0]      pkt_idx_q, pkt_idx_d;
    logic [RW-1:0]   retry_q, retry_d;
    cfg_seq_status_e status_q, status_d;
    uart_config_s    cfg_q, cfg_d;
    logic            sanitized_q, sanitized_d;

    logic cnt_clear;
    logic cnt_en;
    logic cnt_tc;

    cfg_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (cnt_clear),
        .enable_i(cnt_en),
        .tc_o    (cnt_tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pkt_idx_q   <= '0;
            retry_q     <= '0;
            status_q    <= CS_OK;
            cfg_q       <= STD_CONFIG;
            sanitized_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_idx_q   <= pkt_idx_d;
            retry_q     <= retry_d;
            status_q    <= status_d;
            cfg_q       <= cfg_d;
            sanitized_q <= sanitized_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pkt_idx_d       = pkt_idx_q;
        retry_d         = retry_q;
        status_d        = status_q;
        cfg_d           = cfg_q;
        sanitized_d     = sanitized_q;
        tx_fifo_write_o = 1'b0;
        tx_data_o       = 8'h00;
        rx_fifo_read_o  = 1'b0;
        CFR_en_o        = 1'b0;
        done_o          = 1'b0;
        config_o        = STD_CONFIG;
        cnt_clear       = 1'b0;
        cnt_en          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cfg_d       = cfg_i;
                    sanitized_d = 1'b0;
                    if (cfg_i.stop_bits == RESERVED) begin
                        cfg_d.stop_bits = STD_STOP_BITS;
                        sanitized_d     = 1'b1;
                    end
                    pkt_idx_d = '0;
                    retry_d   = '0;
                    state_d   = SEND;
                end
            end

            SEND: begin
                tx_data_o = cfg_packet(pkt_idx_q, cfg_q);
                if (!tx_fifo_full_i) begin
                    tx_fifo_write_o = 1'b1;
                    cnt_clear       = 1'b1;
                    state_d         = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                // A word at the head always beats the timeout in the same cycle
                if (!rx_fifo_empty_i) begin
                    rx_fifo_read_o = 1'b1;
                    if (rx_data_i == ACKN_PKT) begin
                        if (pkt_idx_q == LAST_PKT_IDX) begin
                            state_d  = APPLY;
                            status_d = sanitized_q ? CS_SANITIZED : CS_OK;
                        end else begin
                            pkt_idx_d = pkt_idx_q + 3'd1;
                            retry_d   = '0;
                            state_d   = SEND;
                        end
                    end else begin
                        state_d  = FALLBACK;
                        status_d = CS_BAD_ACK;
                    end
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        retry_d = retry_q + RW'(1);
                        if (retry_d == RW'(MAX_RETRY)) begin
                            state_d  = FALLBACK;
                            status_d = CS_TIMEOUT;
                        end else begin
                            state_d = SEND;
                        end
                    end
                end
            end

            APPLY: begin
                CFR_en_o = 1'b1;
                done_o   = 1'b1;
                config_o = cfg_q;
                state_d  = IDLE;
            end

            FALLBACK: begin
                CFR_en_o = 1'b1;
                done_o   = 1'b1;
                config_o = STD_CONFIG;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q != IDLE);
    assign status_o = status_q;

endmodule

// File: tb/tb_config_master_sequencer.sv
// Directed bench for config_master_sequencer with a scripted RX FIFO responder.
module tb_config_master_sequencer;
    import UART_pkg::*;

    localparam int TO = 16;
    localparam int MR = 3;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    uart_config_s cfg_i = '0;
    logic         tx_fifo_full_i = 1'b0;
    logic         tx_fifo_write_o;
    logic [7:0]   tx_data_o;
    logic         rx_fifo_empty_i = 1'b1;
    logic [7:0]   rx_data_i = 8'h00;
    logic         rx_fifo_read_o;
    logic         busy_o;
    logic         CFR_en_o;
    uart_config_s config_o;
    logic         done_o;
    logic [1:0]   status_o;

    config_master_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY     (MR)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .cfg_i          (cfg_i),
        .tx_fifo_full_i (tx_fifo_full_i),
        .tx_fifo_write_o(tx_fifo_write_o),
        .tx_data_o      (tx_data_o),
        .rx_fifo_empty_i(rx_fifo_empty_i),
        .rx_data_i      (rx_data_i),
        .rx_fifo_read_o (rx_fifo_read_o),
        .busy_o         (busy_o),
        .CFR_en_o       (CFR_en_o),
        .config_o       (config_o),
        .done_o         (done_o),
        .status_o       (status_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitor / responder state
    int           cyc = 0;
    int           start_cyc = -1;
    bit           pend_pop = 1'b0;
    logic [7:0]   rxq[$];
    int           due_q[$];
    logic [7:0]   due_w[$];
    logic [7:0]   wr_data[$];
    int           wr_cyc[$];
    int           pop_cyc[$];
    logic [7:0]   pop_w[$];
    int           cfr_n = 0;
    int           cfr_cyc = 0;
    int           wr_full = 0;
    int           stray_done = 0;
    uart_config_s cfr_cfg = '0;
    logic [1:0]   cfr_stat = '0;
    logic         cfr_done = 1'b0;
    int           resp_word[16];
    int           resp_delay[16];

    // Inputs change at the falling edge; strobes are sampled 1 ns later,
    // which is what the DUT acts on at the following rising edge.
    always @(negedge clk_i) begin
        cyc++;
        if (pend_pop && rxq.size() > 0) rxq.delete(0);
        pend_pop = 1'b0;
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            rxq.push_back(due_w[0]);
            due_q.delete(0);
            due_w.delete(0);
        end
        rx_fifo_empty_i = (rxq.size() == 0);
        rx_data_i       = (rxq.size() == 0) ? 8'h00 : rxq[0];
        #1;
        if (start_i && !busy_o && !rst_i) start_cyc = cyc;
        if (tx_fifo_write_o) begin
            if (tx_fifo_full_i) wr_full++;
            if (wr_data.size() < 16 && resp_word[wr_data.size()] >= 0) begin
                due_q.push_back(cyc + resp_delay[wr_data.size()]);
                due_w.push_back(resp_word[wr_data.size()][7:0]);
            end
            wr_data.push_back(tx_data_o);
            wr_cyc.push_back(cyc);
        end
        if (rx_fifo_read_o) begin
            pend_pop = 1'b1;
            pop_cyc.push_back(cyc);
            pop_w.push_back(rx_data_i);
        end
        if (CFR_en_o) begin
            cfr_n++;
            cfr_cyc  = cyc;
            cfr_cfg  = config_o;
            cfr_stat = status_o;
            cfr_done = done_o;
        end
        if (done_o && !CFR_en_o) stray_done++;
    end

    task automatic clear_rec();
        wr_data.delete();
        wr_cyc.delete();
        pop_cyc.delete();
        pop_w.delete();
        cfr_n      = 0;
        wr_full    = 0;
        stray_done = 0;
        start_cyc  = -1;
    endtask

    task automatic set_script(input int w0, input int d0, input int w1, input int d1,
                              input int wr, input int dr);
        for (int i = 0; i < 16; i++) begin
            resp_word[i]  = wr;
            resp_delay[i] = dr;
        end
        resp_word[0] = w0; resp_delay[0] = d0;
        resp_word[1] = w1; resp_delay[1] = d1;
    endtask

    task automatic launch(input uart_config_s c);
        @(negedge clk_i);
        start_i = 1'b1;
        cfg_i   = c;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (cfr_n == 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_done_seen"}, 32'(cfr_n != 0), 32'd1);
    endtask

    task automatic wait_writes(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (wr_data.size() < cnt && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_write_seen"}, 32'(wr_data.size() >= cnt), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   32'(busy_o),          32'd0);
        check({tag, "_txwr"},   32'(tx_fifo_write_o), 32'd0);
        check({tag, "_rxrd"},   32'(rx_fifo_read_o),  32'd0);
        check({tag, "_cfr"},    32'(CFR_en_o),        32'd0);
        check({tag, "_done"},   32'(done_o),          32'd0);
        check({tag, "_status"}, 32'(status_o),        32'd0);
        check({tag, "_config"}, 32'(config_o),        32'h30);
        check({tag, "_txdata"}, 32'(tx_data_o),       32'h00);
    endtask

    task automatic report(input string tag);
        $display("seq %s: writes=%0d pops=%0d cfr=%0d status=%0d config=0x%0h",
                 tag, wr_data.size(), pop_cyc.size(), cfr_n, cfr_stat, cfr_cfg);
    endtask

    // {DW 8-bit, ODD, 1 stop} and the expected packet streams
    uart_config_s cfg_happy = 6'b11_01_00;
    uart_config_s cfg_san   = 6'b00_10_11;
    uart_config_s cfg_other = 6'b00_00_01;
    logic [7:0] exp_happy[5] = '{8'hC0, 8'hC7, 8'hC9, 8'hCC, 8'hD0};
    logic [7:0] exp_san[5]   = '{8'hC0, 8'hC4, 8'hCA, 8'hCC, 8'hD0};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a coincident start: reset wins
        rst_i   = 1'b1;
        start_i = 1'b1;
        cfg_i   = cfg_happy;
        repeat (3) @(negedge clk_i);
        #2;
        check_idle_outputs("reset");
        rst_i   = 1'b0;
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2;
        check("reset_start_ignored", 32'(busy_o), 32'd0);

        // Happy path with immediate acks
        clear_rec();
        set_script(32'hFC, 1, 32'hFC, 1, 32'hFC, 1);
        launch(cfg_happy);
        wait_done("happy", 200);
        repeat (5) @(negedge clk_i);
        report("happy");
        check("happy_nwr", 32'(wr_data.size()), 32'd5);
        check("happy_npop", 32'(pop_cyc.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < wr_data.size()) check($sformatf("happy_wr%0d", i), 32'(wr_data[i]), 32'(exp_happy[i]));
        if (wr_cyc.size() > 0) check("happy_first_lat", 32'(wr_cyc[0] - start_cyc), 32'd1);
        for (int i = 0; i < 4; i++)
            if (i + 1 < wr_cyc.size() && i < pop_cyc.size())
                check($sformatf("happy_pop%0d_to_wr", i), 32'(wr_cyc[i+1] > pop_cyc[i]), 32'd1);
        if (pop_cyc.size() == 5) check("happy_cfr_lat", 32'(cfr_cyc - pop_cyc[4]), 32'd1);
        check("happy_ncfr", 32'(cfr_n), 32'd1);
        check("happy_config", 32'(cfr_cfg), 32'(cfg_happy));
        check("happy_status", 32'(cfr_stat), 32'd0);
        check("happy_done", 32'(cfr_done), 32'd1);
        check("happy_stray_done", 32'(stray_done), 32'd0);
        check("happy_idle_after", 32'(busy_o), 32'd0);

        // Timeout: no acks at all
        clear_rec();
        set_script(-1, 1, -1, 1, -1, 1);
        launch(cfg_happy);
        wait_done("timeout", 300);
        repeat (5) @(negedge clk_i);
        report("timeout");
        check("timeout_nwr", 32'(wr_data.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < wr_data.size()) check($sformatf("timeout_wr%0d", i), 32'(wr_data[i]), 32'hC0);
        if (wr_cyc.size() == 3) begin
            check("timeout_gap01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd16);
            check("timeout_gap12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd16);
            check("timeout_gap_cfr", 32'(cfr_cyc - wr_cyc[2]), 32'd16);
        end
        check("timeout_npop", 32'(pop_cyc.size()), 32'd0);
        check("timeout_config", 32'(cfr_cfg), 32'h30);
        check("timeout_status", 32'(cfr_stat), 32'd2);

        // Bad acknowledge on the second packet
        clear_rec();
        set_script(32'hFC, 1, 32'h55, 1, 32'hFC, 1);
        launch(cfg_happy);
        wait_done("badack", 200);
        repeat (20) @(negedge clk_i);
        report("badack");
        check("badack_nwr", 32'(wr_data.size()), 32'd2);
        check("badack_npop", 32'(pop_cyc.size()), 32'd2);
        if (pop_w.size() == 2) check("badack_word", 32'(pop_w[1]), 32'h55);
        if (pop_cyc.size() == 2) check("badack_cfr_lat", 32'(cfr_cyc - pop_cyc[1]), 32'd1);
        check("badack_config", 32'(cfr_cfg), 32'h30);
        check("badack_status", 32'(cfr_stat), 32'd3);

        // Reserved stop bits with TX backpressure for 5 cycles
        clear_rec();
        set_script(32'hFC, 1, 32'hFC, 1, 32'hFC, 1);
        @(negedge clk_i);
        start_i        = 1'b1;
        cfg_i          = cfg_san;
        tx_fifo_full_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        @(negedge clk_i);
        tx_fifo_full_i = 1'b0;
        wait_done("sanitize", 200);
        repeat (5) @(negedge clk_i);
        report("sanitize");
        check("sanitize_nwr", 32'(wr_data.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < wr_data.size()) check($sformatf("sanitize_wr%0d", i), 32'(wr_data[i]), 32'(exp_san[i]));
        check("sanitize_wr_while_full", 32'(wr_full), 32'd0);
        if (wr_cyc.size() > 0) check("sanitize_first_lat", 32'(wr_cyc[0] - start_cyc), 32'd5);
        check("sanitize_config", 32'(cfr_cfg), 32'h08);
        check("sanitize_status", 32'(cfr_stat), 32'd1);

        // Reset while waiting for an acknowledge
        clear_rec();
        set_script(-1, 1, -1, 1, -1, 1);
        launch(cfg_happy);
        wait_writes("rstwait", 1, 50);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        #2;
        check_idle_outputs("rstwait");
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        report("rstwait");
        check("rstwait_ncfr", 32'(cfr_n), 32'd0);
        check("rstwait_nwr", 32'(wr_data.size()), 32'd1);

        // Ack exactly in the timeout cycle, plus a start pulse while busy
        clear_rec();
        set_script(32'hFC, 15, 32'hFC, 1, 32'hFC, 1);
        launch(cfg_happy);
        wait_writes("edge", 1, 50);
        repeat (2) @(negedge clk_i);
        launch(cfg_other);
        wait_done("edge", 200);
        repeat (5) @(negedge clk_i);
        report("edge");
        check("edge_nwr", 32'(wr_data.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < wr_data.size()) check($sformatf("edge_wr%0d", i), 32'(wr_data[i]), 32'(exp_happy[i]));
        if (wr_cyc.size() > 1) check("edge_gap01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd16);
        check("edge_ncfr", 32'(cfr_n), 32'd1);
        check("edge_config", 32'(cfr_cfg), 32'(cfg_happy));
        check("edge_status", 32'(cfr_stat), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
